// File: rtl/wb_32to16_bridge_if.sv
// Bus bundle for the 32-to-16 Wishbone bridge: upstream 32-bit slave side plus downstream 16-bit master side.
// "slave" is the bridge's own view; "master" is the view of the surrounding system.
interface wb_32to16_bridge_if;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_dat_o;
   logic [3:0]  wbs_sel_i;
   logic        wbs_we_i;
   logic        wbs_tga_i;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_ack_o;

   logic [31:0] wbm_adr_o;
   logic [15:0] wbm_dat_o;
   logic [15:0] wbm_dat_i;
   logic [1:0]  wbm_sel_o;
   logic        wbm_we_o;
   logic        wbm_tga_o;
   logic        wbm_stb_o;
   logic        wbm_cyc_o;
   logic        wbm_ack_i;

   modport slave (
      input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_tga_i, wbs_stb_i, wbs_cyc_i,
      input  wbm_dat_i, wbm_ack_i,
      output wbs_dat_o, wbs_ack_o,
      output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_tga_o, wbm_stb_o, wbm_cyc_o
   );

   modport master (
      output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_tga_i, wbs_stb_i, wbs_cyc_i,
      output wbm_dat_i, wbm_ack_i,
      input  wbs_dat_o, wbs_ack_o,
      input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_tga_o, wbm_stb_o, wbm_cyc_o
   );
endinterface

// File: rtl/wb_32to16_bridge.sv
// Splits each 32-bit Wishbone access into up to two big-endian 16-bit downstream cycles.
// All outputs are registered copies derived from the next state.
module wb_32to16_bridge #(
   parameter bit SKIP_EMPTY_HALF = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   wb_32to16_bridge_if.slave      bus
);
   typedef enum logic [2:0] {S_IDLE, S_HI, S_GAP, S_LO, S_DONE} state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [31:2] r_adr;
   logic [31:0] r_dat;
   logic [3:0]  r_sel;
   logic        r_we;
   logic        r_tga;

   logic [31:2] w_lat_adr;
   logic [31:0] w_lat_dat;
   logic [3:0]  w_lat_sel;
   logic        w_lat_we;
   logic        w_lat_tga;
   logic        w_go;
   logic        w_need_lo;
   logic        w_dn_ack;
   logic        w_unused_adr;

   logic        r_wbs_ack;
   logic [31:0] r_wbs_dat;
   logic [31:0] r_wbm_adr;
   logic [15:0] r_wbm_dat;
   logic [1:0]  r_wbm_sel;
   logic        r_wbm_we;
   logic        r_wbm_tga;
   logic        r_wbm_stb;
   logic        r_wbm_cyc;

   assign w_unused_adr = ^bus.wbs_adr_i[1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // In IDLE the request fields come straight from the bus so the first half can be issued on the accept edge.
   always_comb begin
      w_lat_adr    = r_adr;
      w_lat_dat    = r_dat;
      w_lat_sel    = r_sel;
      w_lat_we     = r_we;
      w_lat_tga    = r_tga;
      w_state_next = r_state;
      w_go         = bus.wbs_cyc_i & bus.wbs_stb_i;
      w_dn_ack     = bus.wbs_cyc_i & bus.wbm_ack_i;
      if (r_state == S_IDLE) begin
         w_lat_adr = bus.wbs_adr_i[31:2];
         w_lat_dat = bus.wbs_dat_i;
         w_lat_sel = bus.wbs_sel_i;
         w_lat_we  = bus.wbs_we_i;
         w_lat_tga = bus.wbs_tga_i;
      end
      w_need_lo = !SKIP_EMPTY_HALF || (w_lat_sel[1:0] != 2'b00);
      case (r_state)
         S_IDLE: begin
            if (w_go) begin
               if (SKIP_EMPTY_HALF && (w_lat_sel == 4'b0000))
                  w_state_next = S_DONE;
               else if (SKIP_EMPTY_HALF && (w_lat_sel[3:2] == 2'b00))
                  w_state_next = S_LO;
               else
                  w_state_next = S_HI;
            end
         end
         S_HI: begin
            if (!bus.wbs_cyc_i)
               w_state_next = S_IDLE;
            else if (w_dn_ack)
               w_state_next = w_need_lo ? S_GAP : S_DONE;
         end
         S_GAP:   w_state_next = bus.wbs_cyc_i ? S_LO : S_IDLE;
         S_LO: begin
            if (!bus.wbs_cyc_i)
               w_state_next = S_IDLE;
            else if (w_dn_ack)
               w_state_next = S_DONE;
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_adr     <= '0;
         r_dat     <= '0;
         r_sel     <= '0;
         r_we      <= 1'b0;
         r_tga     <= 1'b0;
         r_wbs_ack <= 1'b0;
         r_wbm_adr <= '0;
         r_wbm_dat <= '0;
         r_wbm_sel <= '0;
         r_wbm_we  <= 1'b0;
         r_wbm_tga <= 1'b0;
         r_wbm_stb <= 1'b0;
         r_wbm_cyc <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_go) begin
            r_adr <= w_lat_adr;
            r_dat <= w_lat_dat;
            r_sel <= w_lat_sel;
            r_we  <= w_lat_we;
            r_tga <= w_lat_tga;
         end
         r_wbs_ack <= (w_state_next == S_DONE);
         r_wbm_stb <= (w_state_next == S_HI) || (w_state_next == S_LO);
         r_wbm_cyc <= (w_state_next == S_HI) || (w_state_next == S_GAP) || (w_state_next == S_LO);
         if (w_state_next == S_HI) begin
            r_wbm_adr <= {w_lat_adr, 2'b00};
            r_wbm_sel <= w_lat_sel[3:2];
            r_wbm_dat <= w_lat_dat[31:16];
            r_wbm_we  <= w_lat_we;
            r_wbm_tga <= w_lat_tga;
         end else if (w_state_next == S_LO) begin
            r_wbm_adr <= {w_lat_adr, 2'b10};
            r_wbm_sel <= w_lat_sel[1:0];
            r_wbm_dat <= w_lat_dat[15:0];
            r_wbm_we  <= w_lat_we;
            r_wbm_tga <= w_lat_tga;
         end
      end
   end

   // Half gi = 1 is the HI word (captured in S_HI), gi = 0 the LO word (captured in S_LO).
   for (genvar gi = 0; gi < 2; gi++) begin : g_capture
      localparam state_t CAP_STATE = (gi == 1) ? S_HI : S_LO;
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_wbs_dat[gi*16 +: 16] <= '0;
         end else if (r_state == CAP_STATE && w_dn_ack && !r_we) begin
            r_wbs_dat[gi*16 +: 16] <= bus.wbm_dat_i;
         end
      end
   end

   assign bus.wbs_ack_o = r_wbs_ack;
   assign bus.wbs_dat_o = r_wbs_dat;
   assign bus.wbm_adr_o = r_wbm_adr;
   assign bus.wbm_dat_o = r_wbm_dat;
   assign bus.wbm_sel_o = r_wbm_sel;
   assign bus.wbm_we_o  = r_wbm_we;
   assign bus.wbm_tga_o = r_wbm_tga;
   assign bus.wbm_stb_o = r_wbm_stb;
   assign bus.wbm_cyc_o = r_wbm_cyc;
endmodule

// File: tb/tb_wb_32to16_bridge.sv
// Directed bench for wb_32to16_bridge: scripted upstream requests against a small modal 16-bit slave.
module tb_wb_32to16_bridge;
   logic clk = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk = ~clk;

   wb_32to16_bridge_if bus();

   wb_32to16_bridge #(.SKIP_EMPTY_HALF(1'b1)) dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   // Slave modes: 0 = one registered ack per stb, 1 = ack follows stb one cycle late, 2 = ack always high, 3 = never ack.
   int          slv_mode = 0;
   logic        slv_ack_r = 1'b0;
   logic [15:0] slv_hi = 16'h0000;
   logic [15:0] slv_lo = 16'h0000;

   always @(posedge clk) begin
      case (slv_mode)
         0:       slv_ack_r <= bus.wbm_stb_o && !slv_ack_r;
         1:       slv_ack_r <= bus.wbm_stb_o;
         default: slv_ack_r <= 1'b0;
      endcase
   end
   assign bus.wbm_ack_i = (slv_mode == 2) ? 1'b1 : slv_ack_r;
   assign bus.wbm_dat_i = bus.wbm_adr_o[1] ? slv_lo : slv_hi;

   // Monitor of accepted downstream transfers and upstream acks.
   logic [31:0] dn_adr [0:63];
   logic [15:0] dn_dat [0:63];
   logic [1:0]  dn_sel [0:63];
   logic        dn_we  [0:63];
   logic        dn_tga [0:63];
   int          dn_n = 0;
   int          up_ack_n = 0;

   always @(posedge clk) begin
      if (!rst_i && bus.wbm_stb_o && bus.wbm_ack_i && dn_n < 64) begin
         dn_adr[dn_n] <= bus.wbm_adr_o;
         dn_dat[dn_n] <= bus.wbm_dat_o;
         dn_sel[dn_n] <= bus.wbm_sel_o;
         dn_we[dn_n]  <= bus.wbm_we_o;
         dn_tga[dn_n] <= bus.wbm_tga_o;
         dn_n         <= dn_n + 1;
      end
      if (bus.wbs_ack_o)
         up_ack_n <= up_ack_n + 1;
   end

   task automatic drive_idle();
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_tga_i = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = 32'h0;
      bus.wbs_dat_i = 32'h0;
   endtask

   // Request presented in cycle 0; lat is the cycle index in which wbs_ack_o is seen (-1 on timeout).
   task automatic do_req(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, input logic tga, output int lat);
      @(negedge clk);
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = dat;
      bus.wbs_sel_i = sel;
      bus.wbs_we_i  = we;
      bus.wbs_tga_i = tga;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.wbs_ack_o) begin
            lat = c;
            break;
         end
      end
      @(negedge clk);
      drive_idle();
      repeat (3) @(negedge clk);
      $display("txn adr=%08h sel=%h we=%0d latency=%0d wbs_dat_o=%08h", adr, sel, we, lat, bus.wbs_dat_o);
   endtask

   task automatic test_reset();
      drive_idle();
      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      checks++; if (bus.wbs_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus.wbs_ack_o); end
      checks++; if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0) begin failures++; $display("FAIL reset_cyc_stb got=%b%b exp=00", bus.wbm_cyc_o, bus.wbm_stb_o); end
      checks++; if (bus.wbs_dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat got=%08h exp=00000000", bus.wbs_dat_o); end
      checks++; if (bus.wbm_adr_o !== 32'h0 || bus.wbm_sel_o !== 2'b00) begin failures++; $display("FAIL reset_adr_sel got=%08h/%b exp=0/00", bus.wbm_adr_o, bus.wbm_sel_o); end
      $display("txn reset done");
   endtask

   task automatic test_read_two_halves();
      int lat, n0, a0;
      slv_mode = 0; slv_hi = 16'h1234; slv_lo = 16'h5678;
      n0 = dn_n; a0 = up_ack_n;
      do_req(32'h0000_0100, 32'h0, 4'hF, 1'b0, 1'b0, lat);
      checks++; if (lat !== 6) begin failures++; $display("FAIL rd2_latency got=%0d exp=6", lat); end
      checks++; if (bus.wbs_dat_o !== 32'h1234_5678) begin failures++; $display("FAIL rd2_data got=%08h exp=12345678", bus.wbs_dat_o); end
      checks++; if (dn_n - n0 !== 2) begin failures++; $display("FAIL rd2_dn_count got=%0d exp=2", dn_n - n0); end
      checks++; if (dn_adr[n0] !== 32'h100 || dn_adr[n0+1] !== 32'h102) begin failures++; $display("FAIL rd2_dn_adr got=%08h,%08h exp=00000100,00000102", dn_adr[n0], dn_adr[n0+1]); end
      checks++; if (dn_sel[n0] !== 2'b11 || dn_sel[n0+1] !== 2'b11 || dn_we[n0] !== 1'b0) begin failures++; $display("FAIL rd2_dn_sel_we got=%b,%b,%b exp=11,11,0", dn_sel[n0], dn_sel[n0+1], dn_we[n0]); end
      checks++; if (up_ack_n - a0 !== 1) begin failures++; $display("FAIL rd2_up_acks got=%0d exp=1", up_ack_n - a0); end
   endtask

   task automatic test_write_hi_only();
      int lat, n0;
      slv_mode = 0;
      n0 = dn_n;
      do_req(32'h0000_0204, 32'hDEAD_BEEF, 4'b1100, 1'b1, 1'b1, lat);
      checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
      checks++; if (dn_n - n0 !== 1) begin failures++; $display("FAIL wr_dn_count got=%0d exp=1", dn_n - n0); end
      checks++; if (dn_adr[n0] !== 32'h204 || dn_dat[n0] !== 16'hDEAD || dn_sel[n0] !== 2'b11) begin failures++; $display("FAIL wr_dn_fields got=%08h/%04h/%b exp=00000204/dead/11", dn_adr[n0], dn_dat[n0], dn_sel[n0]); end
      checks++; if (dn_we[n0] !== 1'b1 || dn_tga[n0] !== 1'b1) begin failures++; $display("FAIL wr_dn_we_tga got=%b%b exp=11", dn_we[n0], dn_tga[n0]); end
      checks++; if (bus.wbs_dat_o !== 32'h1234_5678) begin failures++; $display("FAIL wr_dat_hold got=%08h exp=12345678", bus.wbs_dat_o); end
   endtask

   task automatic test_lo_only_cont_ack();
      int lat, n0, a0;
      slv_mode = 2; slv_hi = 16'hAAAA; slv_lo = 16'hBEEF;
      n0 = dn_n; a0 = up_ack_n;
      do_req(32'h0000_0008, 32'h0, 4'b0011, 1'b0, 1'b0, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL lo_latency got=%0d exp=2", lat); end
      checks++; if (dn_n - n0 !== 1 || dn_adr[n0] !== 32'h0A || dn_sel[n0] !== 2'b11) begin failures++; $display("FAIL lo_dn got=%0d/%08h/%b exp=1/0000000a/11", dn_n - n0, dn_adr[n0], dn_sel[n0]); end
      checks++; if (up_ack_n - a0 !== 1) begin failures++; $display("FAIL lo_up_acks got=%0d exp=1", up_ack_n - a0); end
      checks++; if (bus.wbs_dat_o !== 32'h1234_BEEF) begin failures++; $display("FAIL lo_data got=%08h exp=1234beef", bus.wbs_dat_o); end
   endtask

   task automatic test_gap_ack();
      int lat, n0, a0;
      slv_mode = 1; slv_hi = 16'hCAFE; slv_lo = 16'hF00D;
      n0 = dn_n; a0 = up_ack_n;
      do_req(32'h0000_0040, 32'h0, 4'hF, 1'b0, 1'b0, lat);
      checks++; if (lat !== 6) begin failures++; $display("FAIL gap_latency got=%0d exp=6", lat); end
      checks++; if (dn_n - n0 !== 2 || dn_adr[n0+1] !== 32'h42) begin failures++; $display("FAIL gap_dn got=%0d/%08h exp=2/00000042", dn_n - n0, dn_adr[n0+1]); end
      checks++; if (up_ack_n - a0 !== 1) begin failures++; $display("FAIL gap_up_acks got=%0d exp=1", up_ack_n - a0); end
      checks++; if (bus.wbs_dat_o !== 32'hCAFE_F00D) begin failures++; $display("FAIL gap_data got=%08h exp=cafef00d", bus.wbs_dat_o); end
   endtask

   task automatic test_skip_zero_sel();
      int lat, n0, a0;
      slv_mode = 0; slv_hi = 16'h9999; slv_lo = 16'h8888;
      n0 = dn_n; a0 = up_ack_n;
      do_req(32'h0000_0010, 32'h0, 4'b0000, 1'b0, 1'b0, lat);
      checks++; if (lat !== 1) begin failures++; $display("FAIL skip_latency got=%0d exp=1", lat); end
      checks++; if (dn_n - n0 !== 0 || up_ack_n - a0 !== 1) begin failures++; $display("FAIL skip_counts got=dn%0d/up%0d exp=dn0/up1", dn_n - n0, up_ack_n - a0); end
      checks++; if (bus.wbs_dat_o !== 32'hCAFE_F00D) begin failures++; $display("FAIL skip_data got=%08h exp=cafef00d", bus.wbs_dat_o); end
   endtask

   task automatic test_reset_mid();
      int lat, a0;
      bit found;
      slv_mode = 0; slv_hi = 16'h7777; slv_lo = 16'h6666;
      found = 1'b0;
      @(negedge clk);
      bus.wbs_adr_i = 32'h0000_0300; bus.wbs_sel_i = 4'hF; bus.wbs_we_i = 1'b0;
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.wbm_stb_o && bus.wbm_adr_o[1] && bus.wbm_ack_i) begin
            found = 1'b1;
            break;
         end
      end
      checks++; if (found !== 1'b1) begin failures++; $display("FAIL rstmid_reach_lo got=%b exp=1", found); end
      a0 = up_ack_n;
      rst_i = 1'b1;
      drive_idle();
      @(negedge clk);
      checks++; if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0 || bus.wbs_ack_o !== 1'b0 || bus.wbm_we_o !== 1'b0 || bus.wbm_tga_o !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got=cyc%b stb%b ack%b we%b tga%b exp=all0", bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbs_ack_o, bus.wbm_we_o, bus.wbm_tga_o); end
      checks++; if (bus.wbs_dat_o !== 32'h0 || bus.wbm_adr_o !== 32'h0 || bus.wbm_dat_o !== 16'h0 || bus.wbm_sel_o !== 2'b00) begin failures++; $display("FAIL rstmid_data got=%08h/%08h/%04h/%b exp=0", bus.wbs_dat_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o); end
      rst_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (up_ack_n - a0 !== 0) begin failures++; $display("FAIL rstmid_no_ack got=%0d exp=0", up_ack_n - a0); end
      $display("txn reset during LO half");
      slv_hi = 16'h1111; slv_lo = 16'h2222;
      do_req(32'h0000_0304, 32'h0, 4'hF, 1'b0, 1'b0, lat);
      checks++; if (lat !== 6 || bus.wbs_dat_o !== 32'h1111_2222) begin failures++; $display("FAIL rstmid_next_read got=%0d/%08h exp=6/11112222", lat, bus.wbs_dat_o); end
   endtask

   task automatic test_abort();
      int lat, a0;
      slv_mode = 3;
      a0 = up_ack_n;
      @(negedge clk);
      bus.wbs_adr_i = 32'h0000_0500; bus.wbs_sel_i = 4'hF; bus.wbs_we_i = 1'b0;
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
      @(negedge clk);
      checks++; if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_stb_o !== 1'b1) begin failures++; $display("FAIL abort_in_hi got=%b%b exp=11", bus.wbm_cyc_o, bus.wbm_stb_o); end
      drive_idle();
      @(negedge clk);
      checks++; if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0) begin failures++; $display("FAIL abort_drop got=%b%b exp=00", bus.wbm_cyc_o, bus.wbm_stb_o); end
      repeat (3) @(negedge clk);
      checks++; if (up_ack_n - a0 !== 0) begin failures++; $display("FAIL abort_no_ack got=%0d exp=0", up_ack_n - a0); end
      $display("txn abort during HI half");
      slv_mode = 0; slv_hi = 16'h3333; slv_lo = 16'h4444;
      do_req(32'h0000_0600, 32'h0, 4'hF, 1'b0, 1'b0, lat);
      checks++; if (lat !== 6 || bus.wbs_dat_o !== 32'h3333_4444) begin failures++; $display("FAIL abort_next_read got=%0d/%08h exp=6/33334444", lat, bus.wbs_dat_o); end
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_read_two_halves();
      test_write_hi_only();
      test_lo_only_cont_ack();
      test_gap_ack();
      test_skip_zero_sel();
      test_reset_mid();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
